// File: rtl/sisc_seq.sv
// Multi-cycle SISC instruction sequencer: owns pc, fetches over req/ack, steps DECODE/EXEC/WB.
// Latency 4 cycles per instruction at zero-wait memory; a FETCH stall holds req and address until ack.
module sisc_seq #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_f,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_data,
    input  logic [3:0]        stat,
    output logic [31:0]       ir,
    output logic [ADDR_W-1:0] pc,
    output logic              rf_we,
    output logic [1:0]        alu_op,
    output logic              stat_en,
    output logic              wb_sel,
    output logic              rb_sel,
    output logic              halted
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [31:0]       r_ir;
    logic              r_taken;
    logic              r_req;
    logic              r_rf_we;
    logic [1:0]        r_alu_op;
    logic              r_stat_en;
    logic              r_wb_sel;
    logic              r_rb_sel;
    logic              r_halted;

    logic [3:0]        w_op;
    logic [3:0]        w_mm;
    logic              w_is_alu;
    logic              w_is_clr;
    logic              w_is_br;
    logic              w_cond;
    logic [ADDR_W-1:0] w_target;

    assign w_op     = r_ir[31:28];
    assign w_mm     = r_ir[27:24];
    assign w_is_alu = (w_op == 4'h1) || (w_op == 4'h3);
    assign w_is_clr = (w_op == 4'h2);
    assign w_is_br  = (w_op == 4'h4) || (w_op == 4'h5);
    assign w_cond   = (w_mm == 4'h0) || ((stat & w_mm) != 4'h0);
    assign w_target = (w_op == 4'h4) ? r_ir[ADDR_W-1:0] : r_pc + r_ir[ADDR_W-1:0];

    // Controls are registered one state ahead so every output comes straight from a flop.
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            r_state   <= S_IDLE;
            r_pc      <= '0;
            r_ir      <= '0;
            r_taken   <= 1'b0;
            r_req     <= 1'b0;
            r_rf_we   <= 1'b0;
            r_alu_op  <= 2'b00;
            r_stat_en <= 1'b0;
            r_wb_sel  <= 1'b0;
            r_rb_sel  <= 1'b0;
            r_halted  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state <= S_FETCH;
                    r_req   <= 1'b1;
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        r_ir     <= imem_data;
                        r_req    <= 1'b0;
                        r_rb_sel <= (imem_data[31:28] == 4'h3);
                        r_state  <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (w_op == 4'hF) begin
                        r_halted <= 1'b1;
                        r_rb_sel <= 1'b0;
                        r_state  <= S_HALT;
                    end else begin
                        r_alu_op  <= w_is_alu ? w_mm[1:0] : 2'b00;
                        r_stat_en <= w_is_alu;
                        r_state   <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_stat_en <= 1'b0;
                    r_rf_we   <= w_is_alu || w_is_clr;
                    r_wb_sel  <= w_is_clr;
                    r_taken   <= w_is_br && w_cond;
                    r_state   <= S_WB;
                end
                S_WB: begin
                    r_pc     <= r_taken ? w_target : r_pc + ADDR_W'(1);
                    r_taken  <= 1'b0;
                    r_rf_we  <= 1'b0;
                    r_wb_sel <= 1'b0;
                    r_alu_op <= 2'b00;
                    r_rb_sel <= 1'b0;
                    r_req    <= 1'b1;
                    r_state  <= S_FETCH;
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign imem_req  = r_req;
    assign imem_addr = r_pc;
    assign ir        = r_ir;
    assign pc        = r_pc;
    assign rf_we     = r_rf_we;
    assign alu_op    = r_alu_op;
    assign stat_en   = r_stat_en;
    assign wb_sel    = r_wb_sel;
    assign rb_sel    = r_rb_sel;
    assign halted    = r_halted;

endmodule

// File: tb/tb_sisc_seq.sv
// Bench for sisc_seq: bench-side instruction memory, fetch-address scoreboard and per-state control checks.
module tb_sisc_seq;

    logic        clk = 1'b0;
    logic        rst_f = 1'b0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_data = '0;
    logic [3:0]  stat = 4'h0;
    logic [31:0] ir;
    logic [15:0] pc;
    logic        rf_we;
    logic [1:0]  alu_op;
    logic        stat_en;
    logic        wb_sel;
    logic        rb_sel;
    logic        halted;

    int n_chk = 0;
    int n_bad = 0;
    logic [15:0] sb_q[$];
    logic        prev_req = 1'b0;

    sisc_seq #(.ADDR_W(16)) dut (
        .clk(clk), .rst_f(rst_f),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
        .stat(stat), .ir(ir), .pc(pc),
        .rf_we(rf_we), .alu_op(alu_op), .stat_en(stat_en), .wb_sel(wb_sel), .rb_sel(rb_sel),
        .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req"}, {31'b0, imem_req}, 32'h0);
        chk({tag, "_pc"}, {16'b0, pc}, 32'h0);
        chk({tag, "_ir"}, ir, 32'h0);
        chk({tag, "_ctl"}, {26'b0, rf_we, alu_op, stat_en, wb_sel, rb_sel}, 32'h0);
        chk({tag, "_halt"}, {31'b0, halted}, 32'h0);
    endtask

    // Every new fetch must target the address predicted when the previous instruction went through.
    always @(negedge clk) begin
        if (imem_req && !prev_req) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_fetch", {16'b0, imem_addr}, 32'hFFFF_FFFF);
            end else begin
                chk("sb_fetch_addr", {16'b0, imem_addr}, {16'b0, sb_q.pop_front()});
            end
        end
        prev_req <= imem_req;
    end

    // Entered at a negedge with the DUT in FETCH; returns at the negedge of the next FETCH.
    task automatic do_instr(input logic [31:0] ins, input int waits, input logic [3:0] st,
                            input logic [1:0] e_alu, input logic e_sen, input logic e_we,
                            input logic e_wb, input logic e_rb, input logic [15:0] e_next);
        logic [31:0] ir0;
        ir0 = ir;
        chk("fetch_req", {31'b0, imem_req}, 32'h1);
        for (int w = 0; w < waits; w++) begin
            imem_ack = 1'b0;
            @(negedge clk);
            chk("stall_req", {31'b0, imem_req}, 32'h1);
            chk("stall_ir", ir, ir0);
        end
        imem_ack = 1'b1;
        imem_data = ins;
        stat = st;
        @(negedge clk);
        imem_ack = 1'b0;
        imem_data = '0;
        chk("dec_ir", ir, ins);
        chk("dec_req", {31'b0, imem_req}, 32'h0);
        chk("dec_ctl", {27'b0, rf_we, stat_en, wb_sel, rb_sel, 1'b0}, {27'b0, 1'b0, 1'b0, 1'b0, e_rb, 1'b0});
        @(negedge clk);
        chk("exec_alu", {30'b0, alu_op}, {30'b0, e_alu});
        chk("exec_ctl", {28'b0, rf_we, stat_en, rb_sel, 1'b0}, {28'b0, 1'b0, e_sen, e_rb, 1'b0});
        sb_q.push_back(e_next);
        @(negedge clk);
        chk("wb_alu", {30'b0, alu_op}, {30'b0, e_alu});
        chk("wb_ctl", {28'b0, rf_we, stat_en, wb_sel, rb_sel}, {28'b0, e_we, 1'b0, e_wb, e_rb});
        @(negedge clk);
        chk("next_fetch_req", {31'b0, imem_req}, 32'h1);
        chk("next_pc", {16'b0, pc}, {16'b0, e_next});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Boot
        repeat (3) begin
            @(negedge clk);
            chk_all_zero("rst");
        end
        sb_q.push_back(16'h0000);
        rst_f = 1'b1;
        @(negedge clk);
        chk("boot_req", {31'b0, imem_req}, 32'h1);
        chk("boot_addr", {16'b0, imem_addr}, 32'h0);

        //         instr         wt stat   alu   sen   we    wb    rb    next
        do_instr(32'h1312_0000, 0, 4'h0, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0001);
        do_instr(32'h2050_0000, 3, 4'h0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0002);
        do_instr(32'h3100_0000, 0, 4'h0, 2'd1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0003);
        do_instr(32'h4000_0010, 1, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0010);
        do_instr(32'h5100_FFF0, 0, 4'h1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        do_instr(32'h4000_0010, 0, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0010);
        do_instr(32'h5100_FFF0, 0, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0011);
        do_instr(32'h5C00_0002, 0, 4'h8, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0013);
        do_instr(32'h5600_0005, 0, 4'h9, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0014);
        do_instr(32'h4000_0020, 0, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0020);
        do_instr(32'h4000_FFFF, 0, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'hFFFF);
        do_instr(32'h0000_0000, 2, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        do_instr(32'h4000_0040, 0, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0040);
        do_instr(32'h7FFF_FFFF, 0, 4'hF, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0041);

        // Reset in the middle of EXEC of an ALU_R
        imem_ack = 1'b1;
        imem_data = 32'h1312_0000;
        @(negedge clk);
        imem_ack = 1'b0;
        @(negedge clk);
        chk("mid_exec_sen", {31'b0, stat_en}, 32'h1);
        #2 rst_f = 1'b0;
        #1 chk_all_zero("mid_rst");
        imem_ack = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("mid_rst_we", {31'b0, rf_we}, 32'h0);
            chk("mid_rst_req", {31'b0, imem_req}, 32'h0);
        end
        imem_ack = 1'b0;
        sb_q.push_back(16'h0000);
        rst_f = 1'b1;
        @(negedge clk);
        chk("mid_rst_we_after", {31'b0, rf_we}, 32'h0);
        chk("refetch_req", {31'b0, imem_req}, 32'h1);
        chk("refetch_addr", {16'b0, imem_addr}, 32'h0);

        do_instr(32'h0000_0000, 0, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0001);

        // HLT, then recover through reset
        imem_ack = 1'b1;
        imem_data = 32'hF000_0000;
        @(negedge clk);
        imem_ack = 1'b0;
        chk("hlt_dec_halted", {31'b0, halted}, 32'h0);
        imem_ack = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hlt_halted", {31'b0, halted}, 32'h1);
            chk("hlt_req", {31'b0, imem_req}, 32'h0);
            chk("hlt_ctl", {27'b0, rf_we, alu_op, stat_en, wb_sel}, 32'h0);
        end
        chk("hlt_pc", {16'b0, pc}, 32'h0001);
        imem_ack = 1'b0;
        #2 rst_f = 1'b0;
        #1 chk_all_zero("hlt_rst");
        @(negedge clk);
        sb_q.push_back(16'h0000);
        rst_f = 1'b1;
        @(negedge clk);
        chk("hlt_boot_req", {31'b0, imem_req}, 32'h1);
        @(negedge clk);
        chk("sb_drained", sb_q.size(), 32'h0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
